// File: rtl/noise_mix_pkg.sv
// Shared widths and saturation limits for the noise mixer stage.
package noise_mix_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned SHIFT_W_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 16;

  // One guard bit above the sample width catches overflow of a 16-bit signed add.
  localparam int unsigned SUM_W = 17;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/sat_add16.sv
// Combinational 16-bit signed saturating adder with an overflow flag.
module sat_add16
  import noise_mix_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        sat
);

  logic [SUM_W-1:0] full;

  // Add with sign extension; the two top bits disagree exactly when the result overflowed.
  always_comb begin
    full = {a[15], a} + {b[15], b};
    sat  = full[16] ^ full[15];
    if (!sat) begin
      sum = full[15:0];
    end else if (full[16]) begin
      sum = SAT_MIN;
    end else begin
      sum = SAT_MAX;
    end
  end

endmodule

// File: rtl/noise_mixer.sv
// Adds an attenuated LFSR word to a clean sample stream, saturates, and counts clips.
// Two register stages with a single global advance enable for valid/ready flow control.
module noise_mixer
  import noise_mix_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned SHIFT_W = SHIFT_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  noise_in,
  input  logic [DATA_W-1:0]  sig_in,
  input  logic               sig_valid,
  output logic               sig_ready,
  input  logic               noise_en,
  input  logic [SHIFT_W-1:0] noise_shift,
  input  logic               sat_clr,
  output logic [DATA_W-1:0]  mix_out,
  output logic               mix_valid,
  input  logic               mix_ready,
  output logic [CNT_W-1:0]   sat_count
);

  logic              adv;
  logic [DATA_W-1:0] noise_d;
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_sig_q;
  logic [DATA_W-1:0] s1_noise_q;
  logic [DATA_W-1:0] sum;
  logic              sat;
  logic              sat_event;
  logic [DATA_W-1:0] mix_out_q;
  logic              mix_valid_q;
  logic [CNT_W-1:0]  sat_cnt_q;

  // Whole pipe moves unless the output holds a sample the consumer refuses.
  always_comb begin
    adv       = !(mix_valid_q && !mix_ready);
    sig_ready = adv;
  end

  // Attenuated noise, sampled together with the accepted sample.
  always_comb begin
    noise_d = '0;
    if (noise_en) begin
      noise_d = $signed(noise_in) >>> noise_shift;
    end
  end

  // Stage 1: capture sample and scaled noise; bubbles are loaded as invalid entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sig_q   <= '0;
      s1_noise_q <= '0;
    end else if (adv) begin
      s1_valid_q <= sig_valid;
      s1_sig_q   <= sig_in;
      s1_noise_q <= noise_d;
    end
  end

  sat_add16 u_sat_add16 (
    .a   (s1_sig_q),
    .b   (s1_noise_q),
    .sum (sum),
    .sat (sat)
  );

  // Stage 2: register the saturated sum toward the FIR input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
    end else if (adv) begin
      mix_out_q   <= sum;
      mix_valid_q <= s1_valid_q;
    end
  end

  assign sat_event = adv && s1_valid_q && sat;

  // Saturation counter; clear wins over a coincident event, and the count sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_cnt_q <= '0;
    end else if (sat_clr) begin
      sat_cnt_q <= '0;
    end else if (sat_event && (sat_cnt_q != '1)) begin
      sat_cnt_q <= sat_cnt_q + CNT_W'(1);
    end
  end

  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_noise_mixer.sv
// Scoreboard bench for noise_mixer: stimulus pushes expected outputs, a monitor pops them.
module tb_noise_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] noise_in;
  logic [15:0] sig_in;
  logic        sig_valid;
  logic        sig_ready;
  logic        noise_en;
  logic [3:0]  noise_shift;
  logic        sat_clr;
  logic [15:0] mix_out;
  logic        mix_valid;
  logic        mix_ready;
  logic [15:0] sat_count;

  typedef struct {
    logic [15:0] data;
    int          cnt;
    bit          chk_cnt;
    bit          chk_lat;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  noise_mixer dut (
    .clk         (clk),
    .reset       (reset),
    .noise_in    (noise_in),
    .sig_in      (sig_in),
    .sig_valid   (sig_valid),
    .sig_ready   (sig_ready),
    .noise_en    (noise_en),
    .noise_shift (noise_shift),
    .sat_clr     (sat_clr),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .mix_ready   (mix_ready),
    .sat_count   (sat_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one sample and hold it until accepted; caller runs just after a rising edge.
  task automatic send(input logic [15:0] s, input logic [15:0] n, input bit en,
                      input logic [3:0] sh, input logic [15:0] exp_data, input int exp_cnt,
                      input bit chk_cnt, input bit chk_lat, input string name);
    exp_t e;
    sig_in      = s;
    noise_in    = n;
    noise_en    = en;
    noise_shift = sh;
    sig_valid   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sig_ready) begin
        e.data    = exp_data;
        e.cnt     = exp_cnt;
        e.chk_cnt = chk_cnt;
        e.chk_lat = chk_lat;
        e.acc_cyc = cyc;
        e.name    = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        sig_valid = 1'b0;
        noise_in  = 16'($urandom);
        return;
      end
      @(posedge clk);
      #1;
    end
    errors++;
    $display("FAIL %s: sample not accepted within 50 cycles", name);
    sig_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) return;
      @(posedge clk);
      #1;
    end
    errors++;
    $display("FAIL %s: %0d outputs still pending after 100 cycles", name, sb.size());
  endtask

  // Monitor: every accepted output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && mix_valid && mix_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h, expected no output", mix_out);
      end else begin
        e = sb.pop_front();
        check({e.name, "_data"}, 32'(mix_out), 32'(e.data));
        if (e.chk_cnt) check({e.name, "_satcnt"}, 32'(sat_count), 32'(e.cnt));
        if (e.chk_lat) check({e.name, "_latency"}, 32'(cyc - e.acc_cyc), 32'd2);
      end
    end
  end

  initial begin
    logic [15:0] held;
    reset       = 1'b1;
    sig_in      = '0;
    noise_in    = '0;
    sig_valid   = 1'b0;
    noise_en    = 1'b0;
    noise_shift = '0;
    sat_clr     = 1'b0;
    mix_ready   = 1'b1;

    @(negedge clk);
    check("rst_mix_out", 32'(mix_out), 32'h0);
    check("rst_mix_valid", 32'(mix_valid), 32'h0);
    check("rst_sat_count", 32'(sat_count), 32'h0);
    check("rst_sig_ready", 32'(sig_ready), 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Saturation and scaled-noise vectors.
    send(16'h7000, 16'h4000, 1, 4'd0,  16'h7FFF, 1, 1, 1, "pos_sat");
    send(16'h0100, 16'hACE1, 1, 4'd4,  16'hFBCE, 1, 1, 1, "neg_noise_sh4");
    send(16'h1000, 16'h1234, 1, 4'd2,  16'h148D, 1, 1, 1, "pos_noise_sh2");
    send(16'h8000, 16'hFFFF, 1, 4'd0,  16'h8000, 2, 1, 1, "neg_sat");
    send(16'h8000, 16'hFFFF, 1, 4'd0,  16'h8000, 0, 1, 1, "sat_with_clr");
    sat_clr = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    drain("sat_tests");
    check("sat_clr_count", 32'(sat_count), 32'h0);

    // Extreme shift leaves only the sign.
    send(16'h0005, 16'h8000, 1, 4'd15, 16'h0004, 0, 1, 1, "sh15_neg");
    send(16'h0005, 16'h7FFF, 1, 4'd15, 16'h0005, 0, 1, 1, "sh15_pos");
    drain("shift15");

    // Noise disabled: clean stream passes through back-to-back.
    for (int i = 1; i <= 5; i++) begin
      send(16'(i), 16'($urandom), 0, 4'd0, 16'(i), 0, 1, 1, "noise_off");
    end
    drain("noise_off");

    // Backpressure: stall the consumer for three cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send(16'(17 + i), 16'($urandom), 0, 4'd0, 16'(17 + i), 0, 1, 0, "bp");
        end
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 mix_ready = 1'b0;
        @(negedge clk);
        held = mix_out;
        check("bp_valid_held", 32'(mix_valid), 32'h1);
        check("bp_sig_ready", 32'(sig_ready), 32'h0);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check("bp_sig_ready", 32'(sig_ready), 32'h0);
          check("bp_out_stable", 32'(mix_out), 32'(held));
          check("bp_valid_stable", 32'(mix_valid), 32'h1);
        end
        @(posedge clk);
        #1 mix_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Async reset with two samples in flight.
    send(16'h7000, 16'h4000, 1, 4'd0, 16'h7FFF, 1, 0, 0, "rst_a");
    send(16'h0123, 16'h0000, 0, 4'd0, 16'h0123, 1, 0, 0, "rst_b");
    check("pre_rst_sat_count", 32'(sat_count), 32'h1);
    check("pre_rst_mix_valid", 32'(mix_valid), 32'h1);
    #1 reset = 1'b1;
    sb.delete();
    #1;
    check("async_rst_mix_valid", 32'(mix_valid), 32'h0);
    check("async_rst_mix_out", 32'(mix_out), 32'h0);
    check("async_rst_sat_count", 32'(sat_count), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(mix_valid), 32'h0);
    end
    @(posedge clk);
    #1;
    send(16'h0042, 16'h1111, 0, 4'd0, 16'h0042, 0, 1, 1, "post_rst");
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/noise_mixer.md
# noise_mixer

Downstream stage of the LFSR noise generator in the FIR test-signal chain. It takes clean signed samples from the signal source, adds a programmably attenuated copy of the 16-bit LFSR word, saturates the sum and presents the noisy sample to the FIR filter input. It uses a 2-stage pipeline with valid/ready flow control and counts saturation events for test visibility.

## Interface
Parameters:
- DATA_W, 16, sample and noise word width
- SHIFT_W, 4, width of the noise attenuation control
- CNT_W, 16, width of the saturation-event counter

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- noise_in  input  DATA_W  free-running LFSR word, new value every cycle, treated as two's complement
- sig_in  input  DATA_W  signed clean sample
- sig_valid  input  1  sig_in valid
- sig_ready  output  1  block accepts sig_in this cycle
- noise_en  input  1  0 = noise contribution forced to 0
- noise_shift  input  SHIFT_W  arithmetic right-shift applied to noise
- sat_clr  input  1  synchronous clear of sat_count
- mix_out  output  DATA_W  signed noisy sample
- mix_valid  output  1  mix_out valid
- mix_ready  input  1  downstream (FIR) accepts mix_out
- sat_count  output  CNT_W  number of saturated outputs, sticky at all-ones

## Operation
- Transfer occurs when valid and ready are both high in the same cycle, on either side.
- Global advance: adv = !(mix_valid && !mix_ready); sig_ready = adv (combinational).
- Stage 1 (loads on adv): s1_valid <= sig_valid; s1_sig <= sig_in; s1_noise <= noise_en ? ($signed(noise_in) >>> noise_shift) : 0. The noise word and the config inputs are sampled in the acceptance cycle only.
- Stage 2 (loads on adv): sum = sign-extended 17-bit s1_sig + s1_noise.
  - Sum above 32767 gives 0x7FFF; sum below -32768 gives 0x8000; otherwise sum[15:0].
  - mix_valid <= s1_valid.
- Arithmetic shift floors toward negative infinity. A shift of 15 leaves 0 or -1.
- sat_count increments when stage 2 loads a valid saturated result, and sticks at all-ones.
  - sat_clr has priority: sat_clr and a saturation event in the same cycle give 0.
- Bubbles (sig_valid low while adv is high) propagate as invalid stages. They are not collapsed.

## Timing
- Reset values: mix_out = 0, mix_valid = 0, sat_count = 0, all stage registers = 0. sig_ready = 1 after reset.
- Latency: a sample accepted at edge N appears on mix_out/mix_valid after edge N+1, i.e. 2 register stages, with mix_ready held high.
- Throughput: 1 sample per cycle when mix_ready is high.
- Stall: while mix_valid && !mix_ready, mix_out, mix_valid and the stage-1 registers hold stable and sig_ready = 0. Upstream must hold sig_in.
- Reset mid-operation flushes in-flight samples. Nothing is replayed.
- noise_in changes every cycle. Only the value present at the acceptance edge is used.

## Structure
- Shared package noise_mix_pkg holds:
  - DATA_W and SHIFT_W defaults
  - SAT_MAX = 16'h7FFF and SAT_MIN = 16'h8000 constants
  - the saturating-add function, or equivalent width constants
- One combinational sub-module, sat_add16: 16-bit signed inputs, 16-bit saturated sum, plus a sat flag. It is instantiated in stage 2.
- The pipeline registers, advance logic and counter live in the top module.

## Test plan
- Positive saturation: sig_in = 0x7000, noise_in = 0x4000, shift 0, noise_en = 1 -> mix_out = 0x7FFF two cycles later, sat_count = 1.
- Scaled negative noise: sig_in = 0x0100, noise_in = 0xACE1, shift 4 -> mix_out = 0xFBCE (256 - 1330), sat_count unchanged.
- Negative saturation plus clear: sig_in = 0x8000, noise_in = 0xFFFF, shift 0 -> mix_out = 0x8000, sat_count increments. Assert sat_clr in the same cycle as a second saturation -> sat_count = 0.
- Noise disabled: noise_en = 0, sig_in stream 0x0001..0x0005 with random noise_in -> mix_out = 0x0001..0x0005 in order, back-to-back, latency 2.
- Backpressure: stream 4 samples, drop mix_ready for 3 cycles mid-stream. Required response:
  - sig_ready = 0 during the stall
  - mix_out held stable
  - no loss or duplication; all 4 samples emerge in order
- Async reset mid-stream: assert reset between clock edges with 2 samples in flight -> mix_valid = 0, mix_out = 0 and sat_count = 0 immediately; nothing is emitted after release until new input is accepted.
